fetch_unit: RTL and testbench

SISC fetch/branch front end that sits directly upstream of the control FSM (ctrl) and is driven by ctrl's control outputs.
- Owns the program counter (PC), the instruction register (IR) and the status register.
- Runs the instruction-memory read handshake.
- Decodes IR fields (opcode, mm, ...) into ctrl and evaluates the branch condition.

---
 rtl/sisc_pkg.sv | 34 +++
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit_br_cond.sv | 20 ++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field positions, fetch FSM states.
package sisc_pkg;

  typedef enum logic [3:0] {
    NOOP   = 4'd0,
    LOD    = 4'd1,
    STR    = 4'd2,
    SWP    = 4'd3,
    BRA    = 4'd4,
    BRR    = 4'd5,
    BNE    = 4'd6,
    BNR    = 4'd7,
    ALU_OP = 4'd8,
    HLT    = 4'd15
  } opcode_e;

  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned STAT_W  = 4;

  // LSB positions of the fields within a 32-bit instruction word
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned MM_LSB  = 24;
  localparam int unsigned RD_LSB  = 20;
  localparam int unsigned RS_LSB  = 16;
  localparam int unsigned RT_LSB  = 12;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read handshake between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_br_cond.sv
// Branch condition evaluation from opcode, mask field and status; shared with ctrl.
module br_cond
  import sisc_pkg::*;
(
  input  logic [FIELD_W-1:0] opcode,
  input  logic [FIELD_W-1:0] mm,
  input  logic [STAT_W-1:0]  stat,
  output logic               br_taken
);

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      BRA, BRR: br_taken = (mm == '0) || ((mm & stat) != '0);
      BNE, BNR: br_taken = ((mm & stat) == '0);
      default:  br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// SISC fetch/branch front end: PC, IR, status register and imem read handshake.
// Define FETCH_TIMEOUT_EN to abort fetches that wait TIMEOUT cycles for imem_ack.
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned RST_VEC = 0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic [STAT_W-1:0]  stat_in,
  input  logic               stat_en,
  fetch_unit_if.master       mem,
  output logic [FIELD_W-1:0] opcode,
  output logic [FIELD_W-1:0] mm,
  output logic [FIELD_W-1:0] rd,
  output logic [FIELD_W-1:0] rs,
  output logic [FIELD_W-1:0] rt,
  output logic [IMM_W-1:0]   imm,
  output logic [STAT_W-1:0]  stat,
  output logic [ADDR_W-1:0]  pc,
  output logic               br_taken,
  output logic               fetch_busy,
  output logic               fetch_err
);

  fetch_state_e       state;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  imm_ext;
  logic [ADDR_W-1:0]  target;

  // Field decode straight off the instruction register
  assign opcode     = ir[OPC_LSB +: FIELD_W];
  assign mm         = ir[MM_LSB  +: FIELD_W];
  assign rd         = ir[RD_LSB  +: FIELD_W];
  assign rs         = ir[RS_LSB  +: FIELD_W];
  assign rt         = ir[RT_LSB  +: FIELD_W];
  assign imm        = ir[IMM_LSB +: IMM_W];
  assign fetch_busy = (state == REQ);

  assign imm_ext = ADDR_W'(imm);
  assign target  = br_sel ? imm_ext : pc + imm_ext;

  br_cond u_br_cond (
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .br_taken (br_taken)
  );

  // PC and status register; pc_rst wins over pc_write
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc   <= ADDR_W'(RST_VEC);
      stat <= '0;
    end else begin
      if (pc_rst)        pc <= ADDR_W'(RST_VEC);
      else if (pc_write) pc <= pc_sel ? target : pc + ADDR_W'(1);
      if (stat_en)       stat <= stat_in;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  // Fetch FSM; the request address is latched on entry so later PC writes cannot disturb it
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state         <= IDLE;
      ir            <= '0;
      mem.imem_req  <= 1'b0;
      mem.imem_addr <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt      <= '0;
      fetch_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ir_load) begin
            state         <= REQ;
            mem.imem_req  <= 1'b1;
            mem.imem_addr <= pc;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end
        end
        REQ: begin
          if (mem.imem_ack) begin
            ir           <= mem.imem_rdata;
            mem.imem_req <= 1'b0;
            state        <= IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            ir           <= '0;
            mem.imem_req <= 1'b0;
            state        <= IDLE;
            fetch_err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector tables, scoreboard of fetched words, corner sequences.
module tb_fetch_unit;
  import sisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_f, pc_rst, pc_write, pc_sel, br_sel, ir_load, stat_en;
  logic [3:0]  stat_in;
  logic [3:0]  opcode, mm, rd, rs, rt, stat;
  logic [15:0] imm, pc;
  logic        br_taken, fetch_busy, fetch_err;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) mem_if ();

  fetch_unit dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_rst     (pc_rst),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .ir_load    (ir_load),
    .stat_in    (stat_in),
    .stat_en    (stat_en),
    .mem        (mem_if),
    .opcode     (opcode),
    .mm         (mm),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .imm        (imm),
    .stat       (stat),
    .pc         (pc),
    .br_taken   (br_taken),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        sel;
    logic        bsel;
    logic [15:0] exp_pc;
  } pc_vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [31:0] word;
    logic        exp_taken;
  } br_vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];
  logic [15:0] model_pc;
  pc_vec_t     pv[8];
  br_vec_t     bv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected word and compare it against the decode outputs
  task automatic check_ir();
    logic [31:0] w;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_underflow: got empty queue expected one entry");
      return;
    end
    total--;
    w = sb_q.pop_front();
    chk("opcode", 32'(opcode), 32'(w[31:28]));
    chk("mm",     32'(mm),     32'(w[27:24]));
    chk("rd",     32'(rd),     32'(w[23:20]));
    chk("rs",     32'(rs),     32'(w[19:16]));
    chk("rt",     32'(rt),     32'(w[15:12]));
    chk("imm",    32'(imm),    32'(w[15:0]));
  endtask

  // Full fetch: ir_load pulse, optional wait states, ack with w; optional stray ir_load mid-wait
  task automatic fetch(input logic [31:0] w, input int waits, input bit stray_load);
    int n;
    n = 0;
    ir_load = 1'b1;
    sb_q.push_back(w);
    tick();
    ir_load = 1'b0;
    for (int i = 0; i < waits; i++) begin
      if (mem_if.imem_req) n++;
      chk("addr_wait", 32'(mem_if.imem_addr), 32'(model_pc));
      chk("busy_wait", 32'(fetch_busy), 32'd1);
      if (stray_load && i == 1) ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
    end
    if (mem_if.imem_req) n++;
    chk("addr_ack", 32'(mem_if.imem_addr), 32'(model_pc));
    mem_if.imem_ack   = 1'b1;
    mem_if.imem_rdata = w;
    tick();
    mem_if.imem_ack   = 1'b0;
    mem_if.imem_rdata = $urandom();
    chk("req_cycles", 32'(n), 32'(waits + 1));
    chk("req_done", 32'(mem_if.imem_req), 32'd0);
    chk("busy_done", 32'(fetch_busy), 32'd0);
    check_ir();
  endtask

  initial begin
    pv[0] = '{32'h0000_0005, 1'b1, 1'b1, 16'h0005};
    pv[1] = '{32'h0000_0003, 1'b1, 1'b0, 16'h0008};
    pv[2] = '{32'h0000_0003, 1'b1, 1'b1, 16'h0003};
    pv[3] = '{32'h0000_FFFF, 1'b1, 1'b1, 16'hFFFF};
    pv[4] = '{32'h0000_FFFF, 1'b0, 1'b0, 16'h0000};
    pv[5] = '{32'h0000_0002, 1'b1, 1'b0, 16'h0002};
    pv[6] = '{32'h0000_FFFF, 1'b1, 1'b0, 16'h0001};
    pv[7] = '{32'h0000_0000, 1'b0, 1'b1, 16'h0002};

    bv[0] = '{4'b0001, 32'h4100_0000, 1'b1};
    bv[1] = '{4'b0001, 32'h6100_0000, 1'b0};
    bv[2] = '{4'b0001, 32'h7400_0000, 1'b1};
    bv[3] = '{4'b0001, 32'h5000_0000, 1'b1};
    bv[4] = '{4'b0001, 32'h8100_0000, 1'b0};
    bv[5] = '{4'b0001, 32'h4200_0000, 1'b0};
    bv[6] = '{4'b0001, 32'h6200_0000, 1'b1};
    bv[7] = '{4'b1010, 32'h5800_0000, 1'b1};
    bv[8] = '{4'b1010, 32'hF000_0000, 1'b0};

    rst_f = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    ir_load = 1'b0; stat_in = '0; stat_en = 1'b0;
    mem_if.imem_ack = 1'b0; mem_if.imem_rdata = '0;
    model_pc = 16'h0000;

    #2;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_req", 32'(mem_if.imem_req), 32'h0);
    chk("rst_addr", 32'(mem_if.imem_addr), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_stat", 32'(stat), 32'h0);
    chk("rst_br", 32'(br_taken), 32'h0);
    tick();
    @(negedge clk) rst_f = 1'b1;
    tick();

    // Zero-wait fetch; PC does not move on its own
    fetch(32'h8123_0000, 0, 1'b0);
    chk("pc_after_fetch", 32'(pc), 32'h0);

    // Move PC to 0x0010 via an absolute branch
    fetch(32'h0000_0010, 0, 1'b0);
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    tick();
    pc_write = 1'b0;
    model_pc = 16'h0010;
    chk("pc_0010", 32'(pc), 32'h0010);

    // Three wait states with a stray ir_load mid-wait
    fetch(32'h1234_5678, 3, 1'b1);
    tick();
    chk("stray_load_req", 32'(mem_if.imem_req), 32'h0);
    chk("stray_load_busy", 32'(fetch_busy), 32'h0);

    // PC written while a request is outstanding; address stays latched
    ir_load = 1'b1;
    sb_q.push_back(32'h2ABC_0042);
    tick();
    ir_load = 1'b0;
    pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    pc_write = 1'b0;
    chk("pc_in_req", 32'(pc), 32'h0011);
    chk("addr_frozen", 32'(mem_if.imem_addr), 32'h0010);
    mem_if.imem_ack = 1'b1; mem_if.imem_rdata = 32'h2ABC_0042;
    tick();
    mem_if.imem_ack = 1'b0;
    check_ir();
    model_pc = 16'h0011;

    // PC update table
    for (int i = 0; i < 8; i++) begin
      fetch(pv[i].word, i % 2, 1'b0);
      pc_sel = pv[i].sel; br_sel = pv[i].bsel; pc_write = 1'b1;
      tick();
      pc_write = 1'b0;
      model_pc = pv[i].exp_pc;
      chk($sformatf("pc_tbl%0d", i), 32'(pc), 32'(pv[i].exp_pc));
    end

    // Branch condition table
    for (int i = 0; i < 9; i++) begin
      stat_in = bv[i].st; stat_en = 1'b1;
      tick();
      stat_en = 1'b0;
      stat_in = 4'b1111;
      chk($sformatf("stat_tbl%0d", i), 32'(stat), 32'(bv[i].st));
      fetch(bv[i].word, i % 3, 1'b0);
      chk($sformatf("br_tbl%0d", i), 32'(br_taken), 32'(bv[i].exp_taken));
    end

    // pc_rst beats pc_write
    pc_rst = 1'b1; pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    tick();
    pc_rst = 1'b0; pc_write = 1'b0;
    model_pc = 16'h0000;
    chk("pc_rst_prio", 32'(pc), 32'h0);

    // Async reset in the middle of a fetch; a late ack is ignored
    stat_in = 4'b0110; stat_en = 1'b1;
    tick();
    stat_en = 1'b0;
    fetch(32'h4F00_ABCD, 0, 1'b0);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    chk("pre_rst_req", 32'(mem_if.imem_req), 32'h1);
    #1 rst_f = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_if.imem_req), 32'h0);
    chk("midrst_opcode", 32'(opcode), 32'h0);
    chk("midrst_imm", 32'(imm), 32'h0);
    chk("midrst_stat", 32'(stat), 32'h0);
    chk("midrst_busy", 32'(fetch_busy), 32'h0);
    @(negedge clk) rst_f = 1'b1;
    mem_if.imem_ack = 1'b1; mem_if.imem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_if.imem_ack = 1'b0;
    chk("late_ack_opcode", 32'(opcode), 32'h0);
    chk("late_ack_imm", 32'(imm), 32'h0);
    chk("late_ack_req", 32'(mem_if.imem_req), 32'h0);

`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      fetch(32'h4100_0000, 0, 1'b0);
      n = 0;
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (!mem_if.imem_req) break;
        n++;
        tick();
      end
      chk("to_req_cycles", 32'(n), 32'd15);
      chk("to_req", 32'(mem_if.imem_req), 32'h0);
      chk("to_opcode", 32'(opcode), 32'h0);
      chk("to_err", 32'(fetch_err), 32'h1);
      fetch(32'h5000_0000, 1, 1'b0);
      chk("to_err_sticky", 32'(fetch_err), 32'h1);
    end
`else
    chk("err_tied", 32'(fetch_err), 32'h0);
`endif

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
